// File: rtl/password_ctrl.sv
// password_ctrl: debounced keypad entry, password compare and lock/alarm state machine for the cypher lock
module password_ctrl #(
    parameter logic [23:0] DEBOUNCE_MAX = 24'd1999999,
    parameter logic [31:0] OPEN_MAX     = 32'd499999999,
    parameter logic [31:0] LOCK_MAX     = 32'd999999999,
    parameter logic [3:0]  MAX_ATTEMPTS = 4'd3,
    parameter logic [11:0] DEFAULT_PWD  = 12'h123
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_digit,
    input  logic        btn_digit,
    input  logic        btn_confirm,
    input  logic        btn_clear,
    input  logic        btn_set,
    output logic [11:0] entered_password,
    output logic [3:0]  suffix,
    output logic        lock_open,
    output logic        alarm
);
    typedef enum logic [2:0] {IDLE, ENTRY, OPEN, SETPWD, LOCKOUT} state_t;

    logic [3:0]       raw, s1, s2, s3, lvl, press;
    logic [3:0][23:0] cnt;
    logic             p_digit, p_confirm, p_set, p_clear, digit_ok;
    state_t           state, state_d;
    logic [11:0]      entry_d, pwd, pwd_d;
    logic [1:0]       count, count_d;
    logic [3:0]       attempts, attempts_d, suffix_d;
    logic [31:0]      timer, timer_d;
    logic             lock_open_d, alarm_d;

    assign raw = {btn_set, btn_clear, btn_confirm, btn_digit};

    // per button: 2-FF synchroniser, stability counter, accepted level and one-cycle press pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            lvl   <= '0;
            press <= '0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= (s2[i] != s3[i]) ? 24'd0 : (cnt[i] == DEBOUNCE_MAX ? cnt[i] : cnt[i] + 24'd1);
                lvl[i]   <= (s2[i] == s3[i] && cnt[i] == DEBOUNCE_MAX) ? s2[i] : lvl[i];
                press[i] <= s2[i] == s3[i] && cnt[i] == DEBOUNCE_MAX && s2[i] && !lvl[i];
            end
        end
    end

    assign p_clear   = press[2];
    assign p_confirm = press[1] && !press[2];
    assign p_set     = press[3] && !press[2] && !press[1];
    assign p_digit   = press[0] && !(|press[3:1]);
    assign digit_ok  = p_digit && sw_digit <= 4'd9 && count != 2'd3;

    // state, entry, password, attempts, shared timer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            entered_password <= 12'hAAA;
            count            <= 2'd0;
            pwd              <= DEFAULT_PWD;
            attempts         <= MAX_ATTEMPTS;
            timer            <= 32'd0;
            suffix           <= MAX_ATTEMPTS;
            lock_open        <= 1'b0;
            alarm            <= 1'b0;
        end else begin
            state            <= state_d;
            entered_password <= entry_d;
            count            <= count_d;
            pwd              <= pwd_d;
            attempts         <= attempts_d;
            timer            <= timer_d;
            suffix           <= suffix_d;
            lock_open        <= lock_open_d;
            alarm            <= alarm_d;
        end
    end

    // next state; the timer runs only while OPEN or LOCKOUT and restarts from 0 on any entry
    always_comb begin
        state_d    = state;
        entry_d    = entered_password;
        count_d    = count;
        pwd_d      = pwd;
        attempts_d = attempts;
        timer_d    = 32'd0;
        case (state)
            IDLE: if (digit_ok) state_d = ENTRY;
            ENTRY: begin
                if (p_clear) state_d = IDLE;
                else if (p_confirm) begin
                    if (entered_password == pwd && count == 2'd3) begin
                        state_d    = OPEN;
                        attempts_d = MAX_ATTEMPTS;
                    end else begin
                        attempts_d = attempts - 4'd1;
                        state_d    = (attempts == 4'd1) ? LOCKOUT : IDLE;
                    end
                end
            end
            OPEN: begin
                if (p_clear) state_d = IDLE;
                else if (p_set) state_d = SETPWD;
                else if (timer == OPEN_MAX) state_d = IDLE;
                else timer_d = timer + 32'd1;
            end
            SETPWD: begin
                if (p_clear) state_d = OPEN;
                else if (p_confirm && count == 2'd3) begin
                    pwd_d   = entered_password;
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == LOCK_MAX) begin
                    state_d    = IDLE;
                    attempts_d = MAX_ATTEMPTS;
                end else timer_d = timer + 32'd1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state && state != IDLE) begin
            entry_d = 12'hAAA;
            count_d = 2'd0;
        end else if (digit_ok && state != OPEN && state != LOCKOUT) begin
            entry_d = {entered_password[7:0], sw_digit};
            count_d = count + 2'd1;
        end
    end

    // outputs decoded from the next state so they register alongside it
    always_comb begin
        lock_open_d = state_d == OPEN || state_d == SETPWD;
        alarm_d     = state_d == LOCKOUT;
        suffix_d    = state_d == OPEN ? 4'h0 : state_d == SETPWD ? 4'h5 : state_d == LOCKOUT ? 4'hF : attempts_d;
    end
endmodule

// File: tb/tb_password_ctrl.sv
// tb_password_ctrl: directed scenarios checked every cycle against a behavioural lock model
module tb_password_ctrl;
    localparam int DB = 3, OM = 49, LM = 99, MAXA = 3;
    localparam int B_DIG = 0, B_CNF = 1, B_CLR = 2, B_SET = 3;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_digit;
    logic [3:0]  btns;
    logic [11:0] entered_password;
    logic [3:0]  suffix;
    logic        lock_open, alarm;

    int errors = 0, checks = 0;

    password_ctrl #(
        .DEBOUNCE_MAX(24'd3),
        .OPEN_MAX(32'd49),
        .LOCK_MAX(32'd99),
        .MAX_ATTEMPTS(4'd3),
        .DEFAULT_PWD(12'h123)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_digit(sw_digit),
        .btn_digit(btns[0]),
        .btn_confirm(btns[1]),
        .btn_clear(btns[2]),
        .btn_set(btns[3]),
        .entered_password(entered_password),
        .suffix(suffix),
        .lock_open(lock_open),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    // behavioural model: entered digits as a list, countdowns in cycles left
    int            mode, tries, left, m_pwd;
    int            code[$];
    logic [DB+3:0] hist[4];
    logic [3:0]    acc, pend;

    task automatic chk(string name, logic [11:0] got, logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        code.delete();
        tries = MAXA;
        m_pwd = 'h123;
        left = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        acc = '0;
        pend = '0;
    endtask

    task automatic model_fsm(logic [3:0] p, int sw);
        bit clr, cnf, st, dok;
        clr = p[2];
        cnf = p[1] && !clr;
        st  = p[3] && !clr && !cnf;
        dok = p[0] && !clr && !cnf && !st && sw <= 9 && code.size() < 3;
        case (mode)
            M_IDLE: if (dok) begin code.push_back(sw); mode = M_ENTRY; end
            M_ENTRY: begin
                if (clr) begin code.delete(); mode = M_IDLE; end
                else if (cnf) begin
                    if (code.size() == 3 && ((code[0] << 8) | (code[1] << 4) | code[2]) == m_pwd) begin
                        mode = M_OPEN; left = OM + 1; tries = MAXA;
                    end else begin
                        tries--;
                        mode = (tries == 0) ? M_LOCK : M_IDLE;
                        left = LM + 1;
                    end
                    code.delete();
                end else if (dok) code.push_back(sw);
            end
            M_OPEN: begin
                if (clr) mode = M_IDLE;
                else if (st) mode = M_SET;
                else begin left--; if (left == 0) mode = M_IDLE; end
            end
            M_SET: begin
                if (clr) begin code.delete(); mode = M_OPEN; left = OM + 1; end
                else if (cnf && code.size() == 3) begin
                    m_pwd = (code[0] << 8) | (code[1] << 4) | code[2];
                    code.delete();
                    mode = M_IDLE;
                end else if (dok) code.push_back(sw);
            end
            default: begin left--; if (left == 0) begin mode = M_IDLE; tries = MAXA; end end
        endcase
    endtask

    task automatic model_step(logic [3:0] b, int sw);
        logic [3:0] np;
        model_fsm(pend, sw);
        for (int i = 0; i < 4; i++) begin
            hist[i] = {hist[i][DB+2:0], b[i]};
            np[i] = (&hist[i][DB+3:2]) && !acc[i];
            if (&hist[i][DB+3:2]) acc[i] = 1'b1;
            if (!(|hist[i][DB+3:2])) acc[i] = 1'b0;
        end
        pend = np;
    endtask

    function automatic logic [11:0] exp_entry();
        logic [11:0] v;
        int n;
        v = 12'hAAA;
        n = code.size();
        for (int i = 0; i < n; i++) v[4*i +: 4] = 4'(code[n-1-i]);
        return v;
    endfunction

    function automatic logic [3:0] exp_suffix();
        return mode == M_OPEN ? 4'h0 : mode == M_SET ? 4'h5 : mode == M_LOCK ? 4'hF : 4'(tries);
    endfunction

    // model advances on each rising edge; outputs compared on the falling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step(btns, int'(sw_digit));
            @(negedge clk);
            if (!rst) model_reset();
            chk("cyc_entered", entered_password, exp_entry());
            chk("cyc_suffix", 12'(suffix), 12'(exp_suffix()));
            chk("cyc_lock_open", 12'(lock_open), 12'(mode == M_OPEN || mode == M_SET));
            chk("cyc_alarm", 12'(alarm), 12'(mode == M_LOCK));
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(int idx, int sw);
        sw_digit = 4'(sw);
        btns[idx] = 1'b1;
        cycles(8);
        btns[idx] = 1'b0;
        cycles(10);
    endtask

    task automatic enter(int a, int b, int c);
        press(B_DIG, a);
        press(B_DIG, b);
        press(B_DIG, c);
        press(B_CNF, 0);
    endtask

    initial begin
        rst = 1'b1;
        btns = '0;
        sw_digit = '0;
        #1 rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        chk("rst_entered", entered_password, 12'hAAA);
        chk("rst_suffix", 12'(suffix), 12'h3);
        chk("rst_lock", 12'(lock_open), 12'h0);
        chk("rst_alarm", 12'(alarm), 12'h0);
        // bounce: one accepted press only
        sw_digit = 4'd7;
        for (int i = 0; i < 10; i++) begin
            btns[0] = (i % 2 == 0);
            cycles(2);
        end
        btns[0] = 1'b1;
        cycles(10);
        btns[0] = 1'b0;
        cycles(10);
        chk("bounce_entered", entered_password, 12'hAA7);
        press(B_CLR, 0);
        chk("clear_entered", entered_password, 12'hAAA);
        // open then auto-relock
        enter(1, 2, 3);
        chk("open_lock", 12'(lock_open), 12'h1);
        chk("open_suffix", 12'(suffix), 12'h0);
        cycles(45);
        chk("relock_lock", 12'(lock_open), 12'h0);
        chk("relock_suffix", 12'(suffix), 12'h3);
        chk("relock_entered", entered_password, 12'hAAA);
        // lockout after three failures
        enter(9, 9, 9);
        chk("fail1_suffix", 12'(suffix), 12'h2);
        enter(9, 9, 9);
        chk("fail2_suffix", 12'(suffix), 12'h1);
        enter(9, 9, 9);
        chk("lock_suffix", 12'(suffix), 12'hF);
        chk("lock_alarm", 12'(alarm), 12'h1);
        press(B_DIG, 5);
        chk("lock_ignored", entered_password, 12'hAAA);
        cycles(80);
        chk("unlock_alarm", 12'(alarm), 12'h0);
        chk("unlock_suffix", 12'(suffix), 12'h3);
        // invalid digit and short code
        press(B_DIG, 12);
        chk("bad_digit", entered_password, 12'hAAA);
        press(B_DIG, 1);
        press(B_DIG, 2);
        chk("short_entered", entered_password, 12'hA12);
        press(B_CNF, 0);
        chk("short_suffix", 12'(suffix), 12'h2);
        // password change
        enter(1, 2, 3);
        chk("chg_open", 12'(lock_open), 12'h1);
        press(B_SET, 0);
        chk("chg_set_suffix", 12'(suffix), 12'h5);
        press(B_DIG, 4);
        press(B_DIG, 5);
        press(B_DIG, 6);
        chk("chg_entered", entered_password, 12'h456);
        press(B_CNF, 0);
        chk("chg_locked", 12'(lock_open), 12'h0);
        chk("chg_suffix", 12'(suffix), 12'h3);
        enter(1, 2, 3);
        chk("old_fails", 12'(suffix), 12'h2);
        enter(4, 5, 6);
        chk("new_opens", 12'(lock_open), 12'h1);
        press(B_CLR, 0);
        chk("clr_relock", 12'(lock_open), 12'h0);
        // reset mid password change
        enter(4, 5, 6);
        press(B_SET, 0);
        press(B_DIG, 7);
        chk("mid_set_entered", entered_password, 12'hAA7);
        rst = 1'b0;
        cycles(1);
        chk("mid_rst_entered", entered_password, 12'hAAA);
        chk("mid_rst_suffix", 12'(suffix), 12'h3);
        chk("mid_rst_lock", 12'(lock_open), 12'h0);
        chk("mid_rst_alarm", 12'(alarm), 12'h0);
        rst = 1'b1;
        cycles(2);
        enter(1, 2, 3);
        chk("default_reopens", 12'(lock_open), 12'h1);
        press(B_CLR, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
